// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the ALU share arbiter.
// Optional subtract support is enabled with ALU_ARB_SUB_EN (see alu_share_arbiter).
package alu_arb_pkg;

  localparam int unsigned W = 16;

  // Bit positions inside rsp_flags = {S, Z, C, P, V}
  localparam int unsigned FLG_S = 4;
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_P = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  // Scan NREQ positions starting at ptr and take the first hit.
  always_comb begin
    logic found;
    int unsigned j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 16-bit adder/flag unit between NREQ requesters.
// Result is registered and returned with the winner's ID on a valid/ready channel.
// Define ALU_ARB_SUB_EN to add the per-requester req_sub port (X + ~Y + 1).
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
`ifdef ALU_ARB_SUB_EN
  input  logic [NREQ-1:0]   req_sub,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_z,
  output logic [4:0]        rsp_flags
);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] gnt_idx;
  logic           accept_ok;
  logic           accept;
  logic [W-1:0]   x_sel, y_sel, y_eff;
  logic           cin;
  logic [W:0]     sum;
  logic [4:0]     flags;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (gnt_idx)
  );

  // Handshake: accept while empty, or while the held result is being consumed.
  always_comb begin
    accept_ok = ~rst & ((state_q == StIdle) | rsp_ready);
    req_ready = accept_ok ? grant : '0;
    accept    = |req_ready;
    rsp_valid = (state_q == StHold);
  end

  // Operand select and 17-bit add with flag derivation.
  always_comb begin
    x_sel = req_x[gnt_idx*W +: W];
    y_sel = req_y[gnt_idx*W +: W];
`ifdef ALU_ARB_SUB_EN
    cin   = req_sub[gnt_idx];
`else
    cin   = 1'b0;
`endif
    y_eff = cin ? ~y_sel : y_sel;
    sum   = {1'b0, x_sel} + {1'b0, y_eff} + {{W{1'b0}}, cin};
    flags        = '0;
    flags[FLG_S] = sum[W-1];
    flags[FLG_Z] = ~|sum[W-1:0];
    flags[FLG_C] = sum[W];
    flags[FLG_P] = ~^sum[W-1:0];
    flags[FLG_V] = (x_sel[W-1] & y_eff[W-1] & ~sum[W-1]) |
                   (~x_sel[W-1] & ~y_eff[W-1] & sum[W-1]);
  end

  // Next state: a new accept keeps us holding; a drained result with no new one idles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StHold;
      StHold: if (rsp_ready && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, pointer and result registers; data regs only load on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_flags <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_id    <= gnt_idx;
        rsp_z     <= sum[W-1:0];
        rsp_flags <= flags;
        rr_ptr_q  <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural reference model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic [3:0]  req_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_z;
  logic [4:0]  rsp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_hold;
  int          m_ptr;
  logic [1:0]  m_id;
  logic [15:0] m_z;
  logic [4:0]  m_flags;
  bit          m_acc;
  int          m_w;

  alu_share_arbiter #(
    .NREQ (4),
    .IDW  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
`ifdef ALU_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .rsp_flags (rsp_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: integer sum/difference, range test for overflow.
  task automatic alu_ref(input logic [15:0] x, input logic [15:0] y, input bit sub,
                         output logic [15:0] z, output logic [4:0] f);
    logic [31:0] full;
    int sx, sy, sr;
    full = 32'(x) + (sub ? 32'(16'hFFFF - y) + 32'd1 : 32'(y));
    z    = full[15:0];
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    sr   = sub ? sx - sy : sx + sy;
    f    = {z[15], z == 16'h0, full[16], ($countones(z) % 2) == 0,
            (sr > 32767) || (sr < -32768)};
  endtask

  task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y);
    req_x[i*16 +: 16] = x;
    req_y[i*16 +: 16] = y;
  endtask

  // Compare DUT against the model just before the next edge.
  task automatic check_now();
    logic [3:0] exp_rr;
    bit ok;
    m_w = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (m_w < 0 && req_valid[j]) m_w = j;
    end
    ok     = !rst && (!m_hold || rsp_ready);
    m_acc  = ok && (m_w >= 0);
    exp_rr = m_acc ? 4'(1 << m_w) : 4'h0;
    check("req_ready", 32'(req_ready), 32'(exp_rr));
    check("rsp_valid", 32'(rsp_valid), 32'(m_hold));
    check("rsp_id",    32'(rsp_id),    32'(m_id));
    check("rsp_z",     32'(rsp_z),     32'(m_z));
    check("rsp_flags", 32'(rsp_flags), 32'(m_flags));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_hold = 0; m_ptr = 0; m_id = 0; m_z = 0; m_flags = 0;
    end else if (m_acc) begin
      alu_ref(req_x[m_w*16 +: 16], req_y[m_w*16 +: 16], req_sub[m_w], m_z, m_flags);
      m_id   = 2'(m_w);
      m_hold = 1;
      m_ptr  = (m_w + 1) % 4;
    end else if (m_hold && rsp_ready) begin
      m_hold = 0;
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_now();
    tick();
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1; req_valid = 0; req_x = 0; req_y = 0; req_sub = 0; rsp_ready = 1;
    m_hold = 0; m_ptr = 0; m_id = 0; m_z = 0; m_flags = 0; m_acc = 0; m_w = -1;
    @(posedge clk); #1;
    step();
    rst = 0;

    // 1: single req0, 7FFF + 1
    req_valid = 4'b0001; set_req(0, 16'h7FFF, 16'h0001);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check_now();
    check("t1_z", 32'(rsp_z), 32'h8000);
    check("t1_flags", 32'(rsp_flags), 32'(5'b10001));
    tick();

    // 2: req1, FFFF + 1
    req_valid = 4'b0010; set_req(1, 16'hFFFF, 16'h0001);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check_now();
    check("t2_id", 32'(rsp_id), 32'd1);
    check("t2_flags", 32'(rsp_flags), 32'(5'b01110));
    tick();

    // 3: all four valid from a fresh pointer -> 0,1,2,3,0
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 4; i++) set_req(i, 16'(i * 16'h1111), 16'(16'h0101 + i));
    req_valid = 4'b1111; rsp_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_now();
      check("t3_grant", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
    end

    // 4: back-pressure for 3 cycles, then same-cycle accept on release
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_now();
      check("t4_stall_ready", 32'(req_ready), 32'h0);
      check("t4_stall_id", 32'(rsp_id), 32'd0);
      tick();
    end
    rsp_ready = 1;
    @(negedge clk);
    check_now();
    check("t4_release", 32'(req_ready), 32'(4'b0010));
    tick();

    // 5: reset while holding, then req2+req0 -> req0 wins
    rst = 1; step(); rst = 0;
    req_valid = 4'b0000;
    @(negedge clk);
    check_now();
    check("t5_valid", 32'(rsp_valid), 32'h0);
    tick();
    req_valid = 4'b0101;
    @(negedge clk);
    check_now();
    check("t5_winner", 32'(req_ready), 32'(4'b0001));
    tick();

`ifdef ALU_ARB_SUB_EN
    // 6: subtract 3 - 5
    req_valid = 4'b0001; req_sub = 4'b0001; set_req(0, 16'h0003, 16'h0005);
    step();
    req_valid = 4'b0000; req_sub = 4'b0000;
    @(negedge clk);
    check_now();
    check("t6_z", 32'(rsp_z), 32'hFFFE);
    check("t6_c", 32'(rsp_flags[2]), 32'h0);
    check("t6_s", 32'(rsp_flags[4]), 32'h1);
    check("t6_v", 32'(rsp_flags[0]), 32'h0);
    tick();
`endif

    // Random traffic with occasional reset and back-pressure
    for (int n = 0; n < 300; n++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) set_req(i, pick_operand(), pick_operand());
`ifdef ALU_ARB_SUB_EN
      req_sub = 4'($urandom);
`endif
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 0; req_valid = 0; rsp_ready = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
